// File: rtl/spi_reg_ctrl.sv
// Command/register controller behind the SPI slave byte engine: frames bytes per cs_n
// transaction, owns the register bank and supplies txd_data. Optional watchdog: SPI_REG_WDOG_EN.
module spi_reg_ctrl #(
    parameter int          NUM_REGS    = 8,
    parameter logic [7:0]  DEV_ID      = 8'hA5,
    parameter int          WDOG_CYCLES = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs_n,
    input  logic [7:0]            rxd_data,
    input  logic                  rxd_flag,
    output logic [7:0]            txd_data,
    output logic [NUM_REGS*8-1:0] reg_bus,
    output logic                  wr_stb,
    output logic [6:0]            wr_addr,
    output logic                  err
);
    typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, ERR} state_t;

    localparam logic [7:0] NREG8 = 8'(NUM_REGS);
    localparam logic [6:0] LAST  = 7'(NUM_REGS - 1);

    state_t     state;
    logic [6:0] addr;
    logic [7:0] regs [1:NUM_REGS-1];
    logic       flag_q, cs_q, byte_v;
    logic [7:0] id_val;
    logic [6:0] nxt_addr;

`ifdef SPI_REG_WDOG_EN
    logic [31:0] wdog_cnt;
    logic        wdog_flag;
    assign id_val = {wdog_flag, DEV_ID[6:0]};
`else
    assign id_val = DEV_ID;
`endif

    wire cs_fall = cs_q & ~cs_n;
    assign nxt_addr = (addr == LAST) ? 7'd0 : addr + 7'd1;

    function automatic logic [7:0] rd_val(input logic [6:0] a);
        logic [7:0] v;
        v = id_val;
        for (int i = 1; i < NUM_REGS; i++)
            if (a == 7'(i)) v = regs[i];
        return v;
    endfunction

    always_comb begin
        reg_bus      = '0;
        reg_bus[7:0] = DEV_ID;
        for (int i = 1; i < NUM_REGS; i++)
            reg_bus[8*i +: 8] = regs[i];
    end

    // cs_q resets low so a transaction cut by reset is not re-entered until cs_n goes high
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q <= 1'b0;
            cs_q   <= 1'b0;
            byte_v <= 1'b0;
        end else begin
            flag_q <= rxd_flag;
            cs_q   <= cs_n;
            byte_v <= rxd_flag & ~flag_q & ~cs_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr     <= '0;
            txd_data <= DEV_ID;
            wr_stb   <= 1'b0;
            wr_addr  <= '0;
            err      <= 1'b0;
            for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
`ifdef SPI_REG_WDOG_EN
            wdog_cnt  <= '0;
            wdog_flag <= 1'b0;
`endif
        end else begin
            wr_stb <= 1'b0;
            // cs_n high overrides everything, including a byte_v in the same cycle
            if (cs_n) begin
                state    <= IDLE;
                txd_data <= DEV_ID;
            end else begin
                case (state)
                    IDLE: if (cs_fall) begin
                        state <= CMD;
                        err   <= 1'b0;
                    end
                    CMD: if (byte_v) begin
                        addr <= rxd_data[6:0];
                        if ({1'b0, rxd_data[6:0]} >= NREG8) begin
                            state    <= ERR;
                            err      <= 1'b1;
                            txd_data <= 8'hFF;
                        end else if (rxd_data[7]) begin
                            state <= WDATA;
                        end else begin
                            state    <= RDATA;
                            txd_data <= rd_val(rxd_data[6:0]);
                        end
                    end
                    WDATA: if (byte_v) begin
                        if (addr != 7'd0) begin
                            for (int i = 1; i < NUM_REGS; i++)
                                if (addr == 7'(i)) regs[i] <= rxd_data;
                            wr_stb  <= 1'b1;
                            wr_addr <= addr;
                        end
                        addr <= nxt_addr;
                    end
                    RDATA: if (byte_v) begin
                        addr     <= nxt_addr;
                        txd_data <= rd_val(nxt_addr);
                    end
                    ERR: txd_data <= 8'hFF;
                    default: state <= IDLE;
                endcase
            end
`ifdef SPI_REG_WDOG_EN
            // a timeout clear takes priority over a write landing in the same cycle
            if (wr_stb) begin
                wdog_cnt  <= '0;
                wdog_flag <= 1'b0;
            end else if (wdog_cnt == 32'(WDOG_CYCLES - 1)) begin
                wdog_cnt  <= '0;
                wdog_flag <= 1'b1;
                for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
            end else begin
                wdog_cnt <= wdog_cnt + 32'd1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl (NUM_REGS = 4): stimulus pushes expected txd bytes and
// register writes into queues; monitors pop and compare when the DUT presents them.
module tb_spi_reg_ctrl;
    localparam int NR = 4;
`ifdef SPI_REG_WDOG_EN
    localparam int WD = 100;
`else
    localparam int WD = 1000;
`endif

    logic            clk = 1'b0;
    logic            rst, cs_n, rxd_flag;
    logic [7:0]      rxd_data, txd_data;
    logic [NR*8-1:0] reg_bus;
    logic            wr_stb, err;
    logic [6:0]      wr_addr;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0]  exp_txd [$];
    logic [14:0] exp_wr  [$];

    spi_reg_ctrl #(.NUM_REGS(NR), .DEV_ID(8'hA5), .WDOG_CYCLES(WD)) dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .rxd_data(rxd_data), .rxd_flag(rxd_flag),
        .txd_data(txd_data), .reg_bus(reg_bus), .wr_stb(wr_stb), .wr_addr(wr_addr), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [7:0] exp);
        @(negedge clk);
        exp_txd.push_back(exp);
        rxd_data = b;
        rxd_flag = 1'b1;
        repeat (6) @(negedge clk);
        rxd_flag = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic cs_lo();
        @(negedge clk); cs_n = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic cs_hi();
        @(negedge clk); cs_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // txd monitor: the byte to shift out must be settled well before the next SCK fall
    always @(posedge rxd_flag) begin
        logic [7:0] e;
        repeat (3) @(negedge clk);
        if (exp_txd.size() > 0) begin
            e = exp_txd.pop_front();
            chk("txd_data", 32'(txd_data), 32'(e));
        end
    end

    always @(negedge clk) begin
        logic [14:0] e;
        int a;
        if (!rst && wr_stb) begin
            if (exp_wr.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL wr_unexpected: got wr_stb at addr %0d expected none", wr_addr);
            end else begin
                e = exp_wr.pop_front();
                a = int'(e[14:8]);
                chk("wr_addr", 32'(wr_addr), 32'(e[14:8]));
                chk("wr_data", 32'(reg_bus[8*a +: 8]), 32'(e[7:0]));
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL timeout: got no end of test expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cs_n = 1'b1; rxd_flag = 1'b0; rxd_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(txd_data), 32'hA5);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_wr_stb", 32'(wr_stb), 32'h0);
        chk("rst_wr_addr", 32'(wr_addr), 32'h0);
        chk("rst_reg_bus", 32'(reg_bus), 32'h0000_00A5);
        rst = 1'b0;
        @(negedge clk);

`ifdef SPI_REG_WDOG_EN
        cs_lo();
        send_byte(8'h81, 8'hA5);
        exp_wr.push_back({7'd1, 8'h7F});
        send_byte(8'h7F, 8'hA5);
        cs_hi();
        chk("wdog_pre", 32'(reg_bus[15:8]), 32'h7F);
        repeat (100) @(negedge clk);
        chk("wdog_clear", 32'(reg_bus[15:8]), 32'h00);
        cs_lo();
        send_byte(8'h00, 8'hA5);
        cs_hi();
`else
        // plain read of address 0 and one dummy
        cs_lo();
        chk("idle_txd", 32'(txd_data), 32'hA5);
        send_byte(8'h00, 8'hA5);
        send_byte(8'hFF, 8'h00);
        chk("read_err", 32'(err), 32'h0);
        cs_hi();

        // write burst
        cs_lo();
        send_byte(8'h81, 8'hA5);
        exp_wr.push_back({7'd1, 8'h12});
        send_byte(8'h12, 8'hA5);
        exp_wr.push_back({7'd2, 8'h34});
        send_byte(8'h34, 8'hA5);
        cs_hi();
        chk("wr_burst_bus", 32'(reg_bus), 32'h0034_12A5);

        // read burst with wrap back to the ID register
        cs_lo();
        send_byte(8'h01, 8'h12);
        send_byte(8'h00, 8'h34);
        send_byte(8'h00, 8'h00);
        send_byte(8'h00, 8'hA5);
        cs_hi();

        // out-of-range command
        cs_lo();
        send_byte(8'h90, 8'hFF);
        chk("err_set", 32'(err), 32'h1);
        send_byte(8'hAA, 8'hFF);
        send_byte(8'hBB, 8'hFF);
        cs_hi();
        chk("err_sticky", 32'(err), 32'h1);
        chk("err_no_write", 32'(reg_bus), 32'h0034_12A5);
        cs_lo();
        chk("err_clear", 32'(err), 32'h0);
        cs_hi();

        // cs_n rises mid-byte during the second data byte
        cs_lo();
        send_byte(8'h83, 8'hA5);
        exp_wr.push_back({7'd3, 8'h55});
        send_byte(8'h55, 8'hA5);
        @(negedge clk); rxd_data = 8'h66;
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("partial_idle_txd", 32'(txd_data), 32'hA5);
        chk("partial_bus", 32'(reg_bus), 32'h5534_12A5);

        // byte_v coincident with cs_n rise is dropped
        cs_lo();
        send_byte(8'h82, 8'hA5);
        @(negedge clk); rxd_data = 8'h99; rxd_flag = 1'b1;
        @(negedge clk); cs_n = 1'b1;
        repeat (3) @(negedge clk);
        rxd_flag = 1'b0;
        repeat (2) @(negedge clk);
        chk("drop_bus", 32'(reg_bus), 32'h5534_12A5);

        // reset mid-transaction: rest of the transaction ignored
        cs_lo();
        send_byte(8'h81, 8'hA5);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        send_byte(8'h77, 8'hA5);
        cs_hi();
        chk("rst_abort_bus", 32'(reg_bus), 32'h0000_00A5);
        chk("rst_abort_err", 32'(err), 32'h0);
`endif
        repeat (4) @(negedge clk);
        chk("wr_queue_empty", 32'(exp_wr.size()), 32'h0);
        chk("txd_queue_empty", 32'(exp_txd.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
